// File: rtl/hedios_slot_feeder_pkg.sv
// rtl/hedios_slot_feeder_pkg.sv - shared constants, freeze-state enum and slot packing helper
package hedios_slot_pkg;

  localparam int SLOT_W            = 32;
  localparam int STATUS_FROZEN_BIT = 8;
  localparam int STATUS_FCNT_LSB   = 16;
  localparam int CNT_LSB           = 16;
  localparam int DIP_W             = 8;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } freeze_state_e;

  // Data slot layout: [7:0] switch value, [15:8] zero, [31:16] change count
  function automatic logic [SLOT_W-1:0] pack_data_slot(input logic [DIP_W-1:0] v,
                                                       input logic [15:0] cnt);
    logic [SLOT_W-1:0] s;
    s = '0;
    s[DIP_W-1:0] = v;
    s[CNT_LSB +: 16] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/hedios_slot_feeder_if.sv
// rtl/hedios_slot_feeder_if.sv - switch inputs, control levels and slot/LED outputs of the feeder
interface hedios_slot_feeder_if #(
  parameter int CHANNELS = 3
);
  import hedios_slot_pkg::*;

  logic [CHANNELS*DIP_W-1:0]        dip_in;
  logic                             freeze;
  logic                             clear;
  logic [(CHANNELS+2)*SLOT_W-1:0]   slots_out;
  logic [7:0]                       tick_led;
  logic                             frozen;

  modport master (
    output dip_in, freeze, clear,
    input  slots_out, tick_led, frozen
  );

  modport slave (
    input  dip_in, freeze, clear,
    output slots_out, tick_led, frozen
  );

endinterface

// File: rtl/hedios_slot_feeder_change_counter.sv
// rtl/hedios_slot_feeder_change_counter.sv - per-channel synchroniser, value register and saturating change counter
module change_counter
  import hedios_slot_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             slower_clock,
  input  logic             rst,
  input  logic [DIP_W-1:0] i_dip,
  input  logic             i_clear,
  output logic [DIP_W-1:0] o_v,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DIP_W-1:0] r_s1;
  logic [DIP_W-1:0] r_s2;
  logic [DIP_W-1:0] r_v;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             w_change;

  // Any differing bit between the synchronised level and the held value is one change
  assign w_change = (r_s2 != r_v);

  // Two-flop synchroniser on the raw switch levels, then the value register follows s2
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_v  <= '0;
    end else begin
      r_s1 <= i_dip;
      r_s2 <= r_s1;
      r_v  <= r_s2;
    end
  end

  // Saturating change counter with sticky saturation flag; clear beats a coincident change
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_change) begin
      if (r_cnt == CNT_MAX) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_v   = r_v;
  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/hedios_slot_feeder.sv
// rtl/hedios_slot_feeder.sv - slow-domain producer of HEDIOS slot words with freeze/snapshot and clear
module hedios_slot_feeder
  import hedios_slot_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 slower_clock,
  input  logic                 rst,
  hedios_slot_feeder_if.slave  bus
);

  logic [31:0]                         r_tick;
  freeze_state_e                       r_state;
  freeze_state_e                       w_state_next;
  logic                                w_enter_frozen;
  logic [15:0]                         r_freeze_cnt;

  logic [CHANNELS-1:0][DIP_W-1:0]      w_v;
  logic [CHANNELS-1:0][15:0]           w_cnt16;
  logic [CHANNELS-1:0]                 w_sat;

  logic [CHANNELS:0][SLOT_W-1:0]       w_data_slots;
  logic [CHANNELS:0][SLOT_W-1:0]       r_data_slots;
  logic [SLOT_W-1:0]                   w_status;
  logic [SLOT_W-1:0]                   r_status;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] w_cnt;

    change_counter #(
      .CNT_W (CNT_W)
    ) u_change_counter (
      .slower_clock (slower_clock),
      .rst          (rst),
      .i_dip        (bus.dip_in[DIP_W*c +: DIP_W]),
      .i_clear      (bus.clear),
      .o_v          (w_v[c]),
      .o_cnt        (w_cnt),
      .o_sat        (w_sat[c])
    );

    // Slot field is 16 bits wide: narrower counters zero-extend, wider ones truncate
    assign w_cnt16[c] = 16'(w_cnt);
  end

  // Free-running tick, wraps naturally; clear wins over the increment
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
    end else if (bus.clear) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 32'd1;
    end
  end

  // Freeze state register
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Freeze next-state: follow the freeze level, flag the RUN->FROZEN transition
  always_comb begin
    w_state_next   = r_state;
    w_enter_frozen = 1'b0;
    unique case (r_state)
      RUN: begin
        if (bus.freeze) begin
          w_state_next   = FROZEN;
          w_enter_frozen = 1'b1;
        end
      end
      FROZEN: begin
        if (!bus.freeze) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // Count freeze entries; wraps at 16 bits, clear zeroes it along with the other counters
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      r_freeze_cnt <= '0;
    end else if (bus.clear) begin
      r_freeze_cnt <= '0;
    end else if (w_enter_frozen) begin
      r_freeze_cnt <= r_freeze_cnt + 16'd1;
    end
  end

  // Pack internal state into the candidate data slots and the status word
  always_comb begin
    w_data_slots = '0;
    w_status     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_data_slots[c] = pack_data_slot(w_v[c], w_cnt16[c]);
    end
    w_data_slots[CHANNELS]              = r_tick;
    w_status[CHANNELS-1:0]              = w_sat;
    w_status[STATUS_FROZEN_BIT]         = (r_state == FROZEN);
    w_status[STATUS_FCNT_LSB +: 16]     = r_freeze_cnt;
  end

  // Data slots snapshot on the edge that enters FROZEN and hold until unfreeze; status always tracks
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      r_data_slots <= '0;
      r_status     <= '0;
    end else begin
      if (w_state_next == RUN) begin
        r_data_slots <= w_data_slots;
      end
      r_status <= w_status;
    end
  end

  assign bus.slots_out = {r_status, r_data_slots};
  assign bus.tick_led  = r_tick[7:0];
  assign bus.frozen    = (r_state == FROZEN);

endmodule
